wb_stage_reg: RTL

EX/WB pipeline register and writeback controller for the 3-stage RV32 pipeline.
- Captures the four writeback candidates of the retiring EX instruction plus their 2-bit select, and drives them into the writeback 4:1 mux: ALU result, load data, PC+4 and immediate.
- Waits on the data-memory handshake for loads and stalls EX while it waits.
- Generates the forwarding selects for the two EX operand muxes.

---
 rtl/wb_stage_reg_if.sv | 45 ++++
 rtl/wb_stage_reg.sv | 121 ++++++++++++
 2 files changed

// File: rtl/wb_stage_reg_if.sv
// EX/WB stage bus: EX-side capture inputs, data-memory handshake and the
// writeback/forwarding outputs. master = EX/memory side, slave = WB stage.
interface wb_stage_reg_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5
);
   logic            ex_valid;
   logic            flush;
   logic            ex_reg_write;
   logic [REGW-1:0] ex_rd;
   logic [REGW-1:0] ex_rs1;
   logic [REGW-1:0] ex_rs2;
   logic [1:0]      ex_wb_sel;
   logic [XLEN-1:0] ex_alu_result;
   logic [XLEN-1:0] ex_pc_plus4;
   logic [XLEN-1:0] ex_imm;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ready;

   logic [XLEN-1:0] wb_a;
   logic [XLEN-1:0] wb_b;
   logic [XLEN-1:0] wb_c;
   logic [XLEN-1:0] wb_d;
   logic [1:0]      wb_sel;
   logic [REGW-1:0] wb_rd;
   logic            wb_valid;
   logic            wb_reg_write;
   logic            stall;
   logic [1:0]      fwd_sel_a;
   logic [1:0]      fwd_sel_b;

   modport master (
      output ex_valid, flush, ex_reg_write, ex_rd, ex_rs1, ex_rs2, ex_wb_sel,
             ex_alu_result, ex_pc_plus4, ex_imm, mem_rdata, mem_ready,
      input  wb_a, wb_b, wb_c, wb_d, wb_sel, wb_rd, wb_valid, wb_reg_write,
             stall, fwd_sel_a, fwd_sel_b
   );

   modport slave (
      input  ex_valid, flush, ex_reg_write, ex_rd, ex_rs1, ex_rs2, ex_wb_sel,
             ex_alu_result, ex_pc_plus4, ex_imm, mem_rdata, mem_ready,
      output wb_a, wb_b, wb_c, wb_d, wb_sel, wb_rd, wb_valid, wb_reg_write,
             stall, fwd_sel_a, fwd_sel_b
   );
endinterface

// File: rtl/wb_stage_reg.sv
// EX/WB pipeline register and writeback controller (EMPTY/WAIT/COMMIT).
// Define WB_FORWARD_EN for WB->EX forwarding; otherwise RAW hazards stall one cycle.
module wb_stage_reg #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic           clk,
   input  logic           rst,
   wb_stage_reg_if.slave  bus
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      WAIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [XLEN-1:0] a_reg, a_next;
   logic [XLEN-1:0] b_reg, b_next;
   logic [XLEN-1:0] c_reg, c_next;
   logic [XLEN-1:0] d_reg, d_next;
   logic [1:0]      sel_reg, sel_next;
   logic [REGW-1:0] rd_reg, rd_next;
   logic            rw_reg, rw_next;

   logic            commit;
   logic            reg_write;
   logic            hazard_stall;
   logic            stall_int;
   logic            accept;
   logic [1:0]      fwd_a;
   logic [1:0]      fwd_b;

   assign commit    = (state_reg == COMMIT);
   assign reg_write = commit & rw_reg & (rd_reg != '0);

`ifdef WB_FORWARD_EN
   assign hazard_stall = 1'b0;
   assign fwd_a = (reg_write && rd_reg == bus.ex_rs1) ? 2'b01 : 2'b00;
   assign fwd_b = (reg_write && rd_reg == bus.ex_rs2) ? 2'b01 : 2'b00;
`else
   // Without forwarding, hold EX until the regfile write at the commit edge.
   assign hazard_stall = reg_write & ((rd_reg == bus.ex_rs1) | (rd_reg == bus.ex_rs2));
   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;
`endif

   assign stall_int = (state_reg == WAIT) | hazard_stall;
   assign accept    = bus.ex_valid & ~bus.flush & ~stall_int & (state_reg != WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= EMPTY;
         a_reg     <= '0;
         b_reg     <= '0;
         c_reg     <= '0;
         d_reg     <= '0;
         sel_reg   <= 2'b00;
         rd_reg    <= '0;
         rw_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         c_reg     <= c_next;
         d_reg     <= d_next;
         sel_reg   <= sel_next;
         rd_reg    <= rd_next;
         rw_reg    <= rw_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      c_next     = c_reg;
      d_next     = d_reg;
      sel_next   = sel_reg;
      rd_next    = rd_reg;
      rw_next    = rw_reg;

      case (state_reg)
         EMPTY, COMMIT: begin
            if (accept) begin
               a_next     = bus.ex_alu_result;
               b_next     = '0;
               c_next     = bus.ex_pc_plus4;
               d_next     = bus.ex_imm;
               sel_next   = bus.ex_wb_sel;
               rd_next    = bus.ex_rd;
               rw_next    = bus.ex_reg_write;
               state_next = (bus.ex_wb_sel == 2'b01) ? WAIT : COMMIT;
            end else begin
               state_next = EMPTY;
            end
         end
         WAIT: begin
            if (bus.mem_ready) begin
               b_next     = bus.mem_rdata;
               state_next = COMMIT;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   assign bus.wb_a         = a_reg;
   assign bus.wb_b         = b_reg;
   assign bus.wb_c         = c_reg;
   assign bus.wb_d         = d_reg;
   assign bus.wb_sel       = sel_reg;
   assign bus.wb_rd        = rd_reg;
   assign bus.wb_valid     = commit;
   assign bus.wb_reg_write = reg_write;
   assign bus.stall        = stall_int;
   assign bus.fwd_sel_a    = fwd_a;
   assign bus.fwd_sel_b    = fwd_b;

endmodule
